// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register family: FSM state
// encoding, default stage field widths and statistics counter width.
package pipe_pkg;

    localparam int RD_W      = 5;
    localparam int XLEN      = 32;
    localparam int MEM_WB_DW = RD_W + 2 * XLEN;
    localparam int STAT_W    = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage boundary.
// slave: the stage register itself; master: the surrounding logic driving it.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 2,
    parameter int DATA_W = MEM_WB_DW
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One storage entry of a stage register: valid and control bits are cleared
// by reset and by clear; the data field has no reset and only loads on load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 2,
    parameter int DATA_W = MEM_WB_DW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Valid and control: clear wins over load so a squash never leaves stale ctrl.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
        end
    end

    // Data field: no reset, enabled only by the load strobe.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and
// an optional second (skid) entry selected by SKID. With SKID=1 in_ready is
// a register; with SKID=0 it is combinational from out_ready.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 2,
    parameter int DATA_W = MEM_WB_DW,
    parameter int SKID   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    pipe_stage_reg_if.slave      bus
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0]    stall_cnt,
    output logic [STAT_W-1:0]    flush_cnt
`endif
);
    pipe_state_e       st_q, st_d;
    logic              rdy_q, rdy_d;
    logic              accept, consume;

    logic              main_vld, skid_vld;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              main_load, main_clr, skid_load, skid_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    assign bus.in_ready = (SKID != 0) ? rdy_q : (bus.out_ready | ~main_vld);
    assign accept       = bus.in_valid & bus.in_ready;
    assign consume      = main_vld & bus.out_ready;

    // Main slot refills from the skid entry whenever one is waiting.
    assign main_ctrl_d  = skid_vld ? skid_ctrl : bus.in_ctrl;
    assign main_data_d  = skid_vld ? skid_data : bus.in_data;

    // Next-state and slot enables; flush overrides every transfer.
    always_comb begin
        st_d      = st_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            st_d     = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (st_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        st_d      = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        st_d      = ST_SKID;
                    end else if (consume) begin
                        main_clr  = 1'b1;
                        st_d      = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        st_d      = ST_FULL;
                    end
                end
                default: begin
                    st_d = ST_EMPTY;
                end
            endcase
        end
        rdy_d = (st_d != ST_SKID);
    end

    // State and registered in_ready; ready is high out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q  <= ST_EMPTY;
            rdy_q <= 1'b1;
        end else begin
            st_q  <= st_d;
            rdy_q <= rdy_d;
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (main_load),
        .clear_i (main_clr),
        .ctrl_i  (main_ctrl_d),
        .data_i  (main_data_d),
        .valid_o (main_vld),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (skid_load),
            .clear_i (skid_clr),
            .ctrl_i  (bus.in_ctrl),
            .data_i  (bus.in_data),
            .valid_o (skid_vld),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
        );
    end else begin : g_noskid
        assign skid_vld  = 1'b0;
        assign skid_ctrl = '0;
        assign skid_data = '0;
    end

    assign bus.out_valid = main_vld;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_data  = main_data;

`ifdef PIPE_STAGE_STATS_EN
    logic [STAT_W-1:0] stall_q, flush_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (main_vld && !bus.out_ready) begin
                stall_q <= sat_inc(stall_q);
            end
            if (flush && (main_vld || skid_vld)) begin
                flush_q <= sat_inc(flush_q);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, a vector
// table plus hand sequences, then random traffic against a FIFO model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = 2;
    localparam int DW = MEM_WB_DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic flush0, flush1;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) b0 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) b1 ();

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] st0, fc0, st1, fc1;
`endif

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush0),
        .bus       (b0)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (st0),
        .flush_cnt (fc0)
`endif
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush1),
        .bus       (b1)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (st1),
        .flush_cnt (fc1)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          eov;
        logic [CW-1:0] eoc;
        logic [DW-1:0] eod;
        logic          eir;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl, input logic eov,
                       input logic [CW-1:0] eoc, input logic [DW-1:0] eod, input logic eir);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eoc = eoc; v.eod = eod; v.eir = eir;
        tbl.push_back(v);
    endtask

    // ---------------- reference model: bounded FIFO per instance ----------------
    typedef struct packed {
        logic [CW-1:0] ctl;
        logic [DW-1:0] dat;
    } ent_t;

    ent_t m_ent [2][2];
    int   m_cnt [2];
    logic p_acc [2];
    logic p_con [2];
    logic p_fl  [2];
    ent_t p_e   [2];

    task automatic sample_one(input int d, input logic ov, input logic [CW-1:0] oc,
                              input logic [DW-1:0] od, input logic ir, input logic iv,
                              input logic ordy, input logic fl, input logic [CW-1:0] ic,
                              input logic [DW-1:0] id);
        logic          exp_ir;
        logic [CW-1:0] exp_c;
        exp_ir = (d == 1) ? (m_cnt[1] < 2) : (ordy || (m_cnt[0] == 0));
        exp_c  = (m_cnt[d] > 0) ? m_ent[d][0].ctl : '0;
        chk($sformatf("rnd%0d.out_valid", d), 80'(ov), 80'(m_cnt[d] > 0));
        chk($sformatf("rnd%0d.out_ctrl", d), 80'(oc), 80'(exp_c));
        if (m_cnt[d] > 0) chk($sformatf("rnd%0d.out_data", d), 80'(od), 80'(m_ent[d][0].dat));
        chk($sformatf("rnd%0d.in_ready", d), 80'(ir), 80'(exp_ir));
        p_acc[d] = iv && exp_ir;
        p_con[d] = (m_cnt[d] > 0) && ordy;
        p_fl[d]  = fl;
        p_e[d]   = '{ctl: ic, dat: id};
    endtask

    task automatic update_one(input int d);
        if (p_fl[d]) begin
            m_cnt[d] = 0;
        end else begin
            if (p_con[d]) begin
                m_ent[d][0] = m_ent[d][1];
                m_cnt[d]--;
            end
            if (p_acc[d]) begin
                m_ent[d][m_cnt[d]] = p_e[d];
                m_cnt[d]++;
            end
        end
    endtask

    task automatic model_cycle();
        #1;
        sample_one(0, b0.out_valid, b0.out_ctrl, b0.out_data, b0.in_ready,
                   b0.in_valid, b0.out_ready, flush0, b0.in_ctrl, b0.in_data);
        sample_one(1, b1.out_valid, b1.out_ctrl, b1.out_data, b1.in_ready,
                   b1.in_valid, b1.out_ready, flush1, b1.in_ctrl, b1.in_data);
        @(posedge clk);
        update_one(0);
        update_one(1);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        b0.in_valid = 1'b0; b0.in_ctrl = '0; b0.in_data = '0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_ctrl = '0; b1.in_data = '0; b1.out_ready = 1'b0;
        flush0 = 1'b0;
        flush1 = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state, sampled while reset is still asserted
        chk("rst.d1.out_valid", 80'(b1.out_valid), 80'(0));
        chk("rst.d1.out_ctrl",  80'(b1.out_ctrl),  80'(0));
        chk("rst.d1.in_ready",  80'(b1.in_ready),  80'(1));
        chk("rst.d0.out_valid", 80'(b0.out_valid), 80'(0));
        chk("rst.d0.in_ready",  80'(b0.in_ready),  80'(1));
        reset_n = 1'b1;

        // skid fill: A, B held; C refused while in_ready=0; drain in order
        add(1'b1, 2'd3, 69'h11, 1'b0, 1'b0, 1'b1, 2'd3, 69'h11, 1'b1);
        add(1'b1, 2'd1, 69'h22, 1'b0, 1'b0, 1'b1, 2'd3, 69'h11, 1'b0);
        add(1'b1, 2'd2, 69'h33, 1'b0, 1'b0, 1'b1, 2'd3, 69'h11, 1'b0);
        add(1'b1, 2'd2, 69'h33, 1'b1, 1'b0, 1'b1, 2'd1, 69'h22, 1'b1);
        add(1'b0, 2'd0, 69'h0,  1'b1, 1'b0, 1'b0, 2'd0, 69'h0,  1'b1);
        // streaming 1..8 with no bubbles
        for (int k = 1; k <= 8; k++)
            add(1'b1, CW'(k), DW'(k), 1'b1, 1'b0, 1'b1, CW'(k), DW'(k), 1'b1);
        add(1'b0, 2'd0, 69'h0,  1'b1, 1'b0, 1'b0, 2'd0, 69'h0,  1'b1);
        // flush from SKID state, then flush of a FULL stage with an offered entry
        add(1'b1, 2'd3, 69'h0A, 1'b0, 1'b0, 1'b1, 2'd3, 69'h0A, 1'b1);
        add(1'b1, 2'd3, 69'h0B, 1'b0, 1'b0, 1'b1, 2'd3, 69'h0A, 1'b0);
        add(1'b1, 2'd1, 69'h44, 1'b0, 1'b1, 1'b0, 2'd0, 69'h0,  1'b1);
        add(1'b1, 2'd1, 69'h55, 1'b0, 1'b0, 1'b1, 2'd1, 69'h55, 1'b1);
        add(1'b1, 2'd2, 69'h66, 1'b1, 1'b1, 1'b0, 2'd0, 69'h0,  1'b1);
        add(1'b0, 2'd0, 69'h0,  1'b1, 1'b0, 1'b0, 2'd0, 69'h0,  1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            b1.in_valid  = tbl[i].iv;
            b1.in_ctrl   = tbl[i].ic;
            b1.in_data   = tbl[i].id;
            b1.out_ready = tbl[i].ordy;
            flush1       = tbl[i].fl;
            step();
            chk($sformatf("tbl%0d.out_valid", i), 80'(b1.out_valid), 80'(tbl[i].eov));
            chk($sformatf("tbl%0d.out_ctrl", i),  80'(b1.out_ctrl),  80'(tbl[i].eoc));
            if (tbl[i].eov)
                chk($sformatf("tbl%0d.out_data", i), 80'(b1.out_data), 80'(tbl[i].eod));
            chk($sformatf("tbl%0d.in_ready", i),  80'(b1.in_ready),  80'(tbl[i].eir));
        end
        idle_inputs();

        // SKID=0 back-pressure: in_ready follows out_ready in the same cycle
        b0.in_valid = 1'b1; b0.in_ctrl = 2'd2; b0.in_data = 69'h71; b0.out_ready = 1'b0;
        #1 chk("s0.ready_empty", 80'(b0.in_ready), 80'(1));
        step();
        chk("s0.first_data", 80'(b0.out_data), 80'(69'h71));
        b0.in_data = 69'h72; b0.in_ctrl = 2'd1;
        #1 chk("s0.ready_stall", 80'(b0.in_ready), 80'(0));
        step();
        chk("s0.hold_data", 80'(b0.out_data), 80'(69'h71));
        b0.out_ready = 1'b1;
        #1 chk("s0.ready_go", 80'(b0.in_ready), 80'(1));
        step();
        chk("s0.replace_data", 80'(b0.out_data), 80'(69'h72));
        chk("s0.replace_ctrl", 80'(b0.out_ctrl), 80'(2'd1));
        b0.in_valid = 1'b0;
        step();
        chk("s0.drained", 80'(b0.out_valid), 80'(0));
        idle_inputs();

        // asynchronous reset between edges, then accept right at release
        b1.in_valid = 1'b1; b1.in_ctrl = 2'd3; b1.in_data = 69'h81;
        step();
        chk("ar.loaded", 80'(b1.out_valid), 80'(1));
        b1.in_ctrl = 2'd2; b1.in_data = 69'h82;
        #2 reset_n = 1'b0;
        #1;
        chk("ar.valid_now", 80'(b1.out_valid), 80'(0));
        chk("ar.ctrl_now",  80'(b1.out_ctrl),  80'(0));
        chk("ar.ready_now", 80'(b1.in_ready),  80'(1));
        step();
        chk("ar.held", 80'(b1.out_valid), 80'(0));
        reset_n = 1'b1;
        step();
        chk("ar.first_valid", 80'(b1.out_valid), 80'(1));
        chk("ar.first_data",  80'(b1.out_data),  80'(69'h82));
        chk("ar.first_ctrl",  80'(b1.out_ctrl),  80'(2'd2));

        // random traffic on both instances against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            b0.in_valid  = ($urandom_range(0, 3) != 0);
            b0.in_ctrl   = CW'($urandom);
            b0.in_data   = DW'({$urandom, $urandom, $urandom});
            b0.out_ready = ($urandom_range(0, 2) != 0);
            flush0       = ($urandom_range(0, 24) == 0);
            b1.in_valid  = ($urandom_range(0, 3) != 0);
            b1.in_ctrl   = CW'($urandom);
            b1.in_data   = DW'({$urandom, $urandom, $urandom});
            b1.out_ready = ($urandom_range(0, 2) != 0);
            flush1       = ($urandom_range(0, 24) == 0);
            model_cycle();
        end

`ifdef PIPE_STAGE_STATS_EN
        do_reset();
        b1.in_valid = 1'b1; b1.in_data = 69'h91;
        step();
        b1.in_valid = 1'b0; flush1 = 1'b1;
        step();
        step();
        flush1 = 1'b0; b1.in_valid = 1'b1; b1.in_data = 69'h92;
        step();
        b1.in_valid = 1'b0; flush1 = 1'b1;
        step();
        flush1 = 1'b0;
        chk("stats.flush_cnt", 80'(fc1), 80'(2));
        b1.in_valid = 1'b1; b1.in_data = 69'h93;
        step();
        b1.in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("stats.stall_sat",  80'(st1), 80'(16'hFFFF));
        chk("stats.flush_keep", 80'(fc1), 80'(2));
        chk("stats.d0_stall",   80'(st0), 80'(0));
        chk("stats.d0_flush",   80'(fc0), 80'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
